// File: rtl/sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// sync_debounce_bank
//
// Multi-channel input conditioner for keypad rows/columns and push buttons.
// Each channel passes through a metastability synchroniser chain, a debounce
// filter that only accepts a new level after it has persisted for
// DebounceCycles consecutive cycles, and an optional edge detector that
// produces one-cycle change pulses.
//
// Build option:
//   SYNC_DEBOUNCE_EDGE_DET_EN - when defined, rise_o/fall_o/changed_o carry
//                               registered change pulses. When undefined the
//                               ports remain but are tied to 0 and no edge
//                               registers exist. stable_o is identical in
//                               both builds.
//
// Ports:
//   clk_i      in   1      system clock
//   rst_i      in   1      asynchronous active-high reset
//   async_i    in   Width  unsynchronised pin levels
//   stable_o   out  Width  debounced level per channel
//   rise_o     out  Width  one-cycle pulse when stable_o[n] goes 0->1
//   fall_o     out  Width  one-cycle pulse when stable_o[n] goes 1->0
//   changed_o  out  1      OR of all rise_o and fall_o bits
// ---------------------------------------------------------------------------
module sync_debounce_bank #(
  parameter int               Width          = 4,
  parameter int               ChainLength    = 2,
  parameter int               DebounceCycles = 16,
  parameter logic [Width-1:0] ResetValue     = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] async_i,
  output logic [Width-1:0] stable_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic             changed_o
);

  localparam int CountWidth = $clog2(DebounceCycles + 1);
  localparam logic [CountWidth-1:0] CountLast = CountWidth'(DebounceCycles - 1);

  (* ASYNC_REG = "TRUE" *) logic [ChainLength-1:0][Width-1:0] r_syncChain;

  logic [Width-1:0]      w_syncOut;
  logic [Width-1:0]      r_stable;
  logic [CountWidth-1:0] r_count [Width];
  logic [Width-1:0]      w_accept;

  // Synchroniser: async_i enters at stage 0 and shifts toward the last stage.
  // Only the last stage is allowed to feed any other logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_syncChain <= {ChainLength{ResetValue}};
    end else begin
      r_syncChain <= {r_syncChain[ChainLength-2:0], async_i};
    end
  end

  assign w_syncOut = r_syncChain[ChainLength-1];

  // A channel accepts its new level when it still differs from the stable
  // level and the counter has already seen DebounceCycles-1 differing cycles;
  // the cycle in which the comparison holds is the final one of the run.
  always_comb begin
    w_accept = '0;
    for (int n = 0; n < Width; n++) begin
      w_accept[n] = (w_syncOut[n] != r_stable[n]) && (r_count[n] == CountLast);
    end
  end

  // Debounce filter: any return to the stable level clears the count, so a
  // glitch shorter than DebounceCycles never reaches stable_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stable <= ResetValue;
      for (int n = 0; n < Width; n++) begin
        r_count[n] <= '0;
      end
    end else begin
      for (int n = 0; n < Width; n++) begin
        if (w_syncOut[n] == r_stable[n]) begin
          r_count[n] <= '0;
        end else if (w_accept[n]) begin
          r_stable[n] <= w_syncOut[n];
          r_count[n]  <= '0;
        end else begin
          r_count[n] <= r_count[n] + CountWidth'(1);
        end
      end
    end
  end

  assign stable_o = r_stable;

`ifdef SYNC_DEBOUNCE_EDGE_DET_EN
  logic [Width-1:0] r_rise;
  logic [Width-1:0] r_fall;
  logic             r_changed;

  // Pulses are registered from the same acceptance term that updates
  // r_stable, so they line up with the first cycle showing the new level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_accept & w_syncOut;
      r_fall    <= w_accept & ~w_syncOut;
      r_changed <= |w_accept;
    end
  end

  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign changed_o = r_changed;
`else
  assign rise_o    = '0;
  assign fall_o    = '0;
  assign changed_o = 1'b0;
`endif

endmodule
